// File: rtl/seq_restoring_divider_if.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider_if
// Request/result bundle for the sequential restoring divider.
//   master : drives start/dividend/divisor, observes the result
//   slave  : the divider itself
// Signals:
//   start    request a division (sampled on rising clk)
//   dividend DW-bit unsigned dividend
//   divisor  VW-bit unsigned divisor
//   busy     division in progress
//   done     one-cycle result-valid pulse
//   quotient DW-bit quotient, remainder VW-bit remainder
//   div_zero result came from a zero divisor
// ---------------------------------------------------------------------------
interface seq_restoring_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seq_restoring_divider_if.slave (request in, result out)
// Timing: a start accepted on edge A produces done after edge A+DW+1
// (one load edge, DW step edges, one commit edge). A zero divisor skips
// the step edges and commits after edge A+2.
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_restoring_divider_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int            CW     = $clog2(DW + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DW);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    // Dividend shifts out of the top while quotient bits shift in at the
    // bottom, so after DW steps this register holds the quotient.
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_div;
    // The settled partial remainder is always below the divisor, so VW bits
    // hold it; the VW+1-bit value only exists as the shifted trial operand.
    logic [VW-1:0] r_rem;
    // Zero-divisor latency: 1 = detected on the accept edge, 2 = commit next.
    logic [1:0]    r_zdly;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rmd;
    logic          r_dz;

    logic [VW:0]   w_shift;
    logic          w_ge;
    logic [VW-1:0] w_diff;

    assign w_shift = {r_rem, r_dvd[DW-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    // Only used when w_ge, where the true difference is below the divisor.
    assign w_diff  = w_shift[VW-1:0] - r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_zdly  <= '0;
            r_quot  <= '0;
            r_rmd   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_zdly == 2'd2) begin
                        r_zdly  <= 2'd0;
                        r_state <= S_DONE;
                        r_quot  <= '1;
                        r_rmd   <= r_dvd[VW-1:0];
                        r_dz    <= 1'b1;
                    end else if (r_zdly == 2'd1) begin
                        // start is not taken while a zero-divisor result
                        // is still on its way out
                        r_zdly  <= 2'd2;
                        r_state <= S_IDLE;
                    end else if (bus.start) begin
                        r_dvd <= bus.dividend;
                        r_div <= bus.divisor;
                        r_rem <= '0;
                        r_cnt <= '0;
                        r_dz  <= 1'b0;
                        if (bus.divisor == '0) begin
                            r_zdly  <= 2'd1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_cnt == C_LAST) begin
                        r_state <= S_DONE;
                        r_quot  <= r_dvd;
                        r_rmd   <= r_rem;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        r_rem <= w_ge ? w_diff : w_shift[VW-1:0];
                        r_dvd <= {r_dvd[DW-2:0], w_ge};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rmd;
    assign bus.div_zero  = r_dz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_restoring_divider
// Directed stimulus for seq_restoring_divider with a result scoreboard:
// each launch pushes the expected quotient/remainder/div_zero and the edge
// number on which done must appear; each done pops and compares.
// ---------------------------------------------------------------------------
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seq_restoring_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        int            edge_n;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   saw_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic launch(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        e.dz     = (dvs == '0);
        e.q      = e.dz ? {DW{1'b1}} : dvd / {4'd0, dvs};
        e.r      = e.dz ? dvd[VW-1:0] : VW'(dvd % {4'd0, dvs});
        e.edge_n = edge_cnt + 1 + (e.dz ? 2 : DW + 1);
        sb.push_back(e);
    endtask

    // Waits for done. Unless hold is set, start is rewritten each cycle from
    // pulse[n] (n = cycles since accept), with 9/3 as the intruding operands.
    task automatic wait_done(input string tag, input int budget, input logic [31:0] pulse,
                             input bit hold, output bit busy_seen);
        int   n    = 0;
        bit   seen = 1'b0;
        exp_t e;
        busy_seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_seen = 1'b1;
            if (bus.done) seen = 1'b1;
            else if (!hold) begin
                bus.start = pulse[n];
                if (pulse[n]) begin
                    bus.dividend = 8'd9;
                    bus.divisor  = 4'd3;
                end
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_quotient"},  32'(bus.quotient),  32'(e.q));
                chk({tag, "_remainder"}, 32'(bus.remainder), 32'(e.r));
                chk({tag, "_div_zero"},  32'(bus.div_zero),  32'(e.dz));
                chk({tag, "_done_edge"}, 32'(edge_cnt),      32'(e.edge_n));
                chk({tag, "_busy_low"},  32'(bus.busy),      32'd0);
                $display("%s: q=%0d r=%0d dz=%0d at edge %0d", tag, bus.quotient,
                         bus.remainder, bus.div_zero, edge_cnt);
            end
        end
    endtask

    task automatic quiet(input string tag, input int cycles);
        int extra = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk(tag, 32'(extra), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_quotient"},  32'(bus.quotient),  32'd0);
        chk({tag, "_remainder"}, 32'(bus.remainder), 32'd0);
        chk({tag, "_div_zero"},  32'(bus.div_zero),  32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Reset state
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First start right after release: 200/7 -> 28 r 4, done on 9th edge
        launch(8'd200, 4'd7);
        wait_done("div_200_7", 20, 32'd0, 1'b0, saw_busy);
        chk("div_200_7_busy_seen", 32'(saw_busy), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("result_held_q", 32'(bus.quotient), 32'd28);

        launch(8'd255, 4'd15);
        wait_done("div_255_15", 20, 32'd0, 1'b0, saw_busy);
        launch(8'd5, 4'd9);
        wait_done("div_5_9", 20, 32'd0, 1'b0, saw_busy);

        // Zero divisor: done on 2nd edge, busy never high
        launch(8'd100, 4'd0);
        wait_done("div_100_0", 20, 32'd0, 1'b0, saw_busy);
        chk("div_100_0_no_busy", 32'(saw_busy), 32'd0);
        @(negedge clk);

        // start pulsed with 9/3 at steps 3 and 7 of a 200/7 run is ignored
        launch(8'd200, 4'd7);
        wait_done("ignore_start", 20, (32'd1 << 3) | (32'd1 << 7), 1'b0, saw_busy);
        quiet("ignore_start_no_extra_done", 12);

        // Reset at step 4 aborts the run
        launch(8'd200, 4'd7);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        rst_n = 1'b1;
        sb.delete();
        quiet("midrun_reset_no_done", 14);
        launch(8'd9, 4'd3);
        wait_done("after_reset_9_3", 20, 32'd0, 1'b0, saw_busy);
        @(negedge clk);

        // Back-to-back with start held high, operands changed in each DONE cycle
        launch(8'd200, 4'd7);
        wait_done("b2b_200_7", 20, 32'd0, 1'b1, saw_busy);
        launch(8'd255, 4'd15);
        wait_done("b2b_255_15", 20, 32'd0, 1'b1, saw_busy);
        launch(8'd100, 4'd0);
        wait_done("b2b_100_0", 20, 32'd0, 1'b1, saw_busy);
        bus.start = 1'b0;
        quiet("b2b_tail_no_done", 12);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
